// File: rtl/rsa_top.sv
// rsa_top: iterative modular-exponentiation engine, result = data^key mod N.
// A right-to-left square-and-multiply loop handles one key bit per clock.
//
// Ports:
//   clk    - system clock, rising edge active
//   rst_n  - asynchronous active-low reset
//   start  - launch request, level-sampled in IDLE/DONE
//   data   - base (message or ciphertext)
//   N      - modulus
//   key    - exponent
//   result - data^key mod N, valid while Done=1
//   Done   - completion flag, held until the next launch
module rsa_top #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] data,
    input  logic [W-1:0] N,
    input  logic [W-1:0] key,
    output logic [W-1:0] result,
    output logic         Done
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

    state_t          state;
    logic [W-1:0]    base;
    logic [W-1:0]    acc;
    logic [W-1:0]    e;
    logic [W-1:0]    n_r;
    logic [CW-1:0]   cnt;
    logic [2*W-1:0]  prod_ab;
    logic [2*W-1:0]  prod_bb;

    // Remainder with "mod 0" defined as 0.
    function automatic logic [W-1:0] mod_n(input logic [2*W-1:0] x, input logic [W-1:0] m);
        logic [2*W-1:0] r;
        r = '0;
        if (m != '0)
            r = x % {{W{1'b0}}, m};
        return r[W-1:0];
    endfunction

    always_comb begin
        prod_ab = {{W{1'b0}}, acc}  * {{W{1'b0}}, base};
        prod_bb = {{W{1'b0}}, base} * {{W{1'b0}}, base};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            result <= '0;
            Done   <= 1'b0;
            base   <= '0;
            acc    <= '0;
            e      <= '0;
            n_r    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (state == DONE) begin
                        result <= acc;
                        Done   <= 1'b1;
                    end
                    // The raw base is parked in 'base' and reduced in LOAD.
                    if (start) begin
                        base  <= data;
                        n_r   <= N;
                        e     <= key;
                        Done  <= 1'b0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    base  <= mod_n({{W{1'b0}}, base}, n_r);
                    acc   <= mod_n({{(2*W-1){1'b0}}, 1'b1}, n_r);
                    cnt   <= '0;
                    state <= CALC;
                end
                CALC: begin
                    if (e[0])
                        acc <= mod_n(prod_ab, n_r);
                    base <= mod_n(prod_bb, n_r);
                    e    <= e >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(W - 1))
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_top.sv
// Scoreboard bench for rsa_top: the stimulus process pushes expected results
// (from a repeated-multiplication reference) and the cycle Done must rise on;
// a monitor pops and compares whenever Done rises.
module tb_rsa_top;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [5:0] data;
    logic [5:0] N;
    logic [5:0] key;
    logic [5:0] result;
    logic       Done;

    rsa_top #(.W(6)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .data   (data),
        .N      (N),
        .key    (key),
        .result (result),
        .Done   (Done)
    );

    typedef struct {
        int res;
        int due;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   exp_prev = 0;
    logic prev_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference: plain repeated multiplication, mod 0 defined as 0.
    function automatic int model(input int d, input int n, input int k);
        int r;
        if (n == 0) return 0;
        r = 1 % n;
        for (int i = 0; i < k; i++)
            r = (r * (d % n)) % n;
        return r;
    endfunction

    // Monitor: compare on every rising Done.
    always @(negedge clk) begin
        if (rst_n && Done && !prev_done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check("result", int'(result), x.res);
                check("latency", cyc, x.due);
            end
        end
        prev_done = Done;
    end

    task automatic launch(input int d, input int n, input int k, input int hold);
        int r;
        r = model(d, n, k);
        @(negedge clk);
        data  = 6'(d);
        N     = 6'(n);
        key   = 6'(k);
        start = 1'b1;
        @(posedge clk);
        #1;
        check("done_drop", int'(Done), 0);
        check("result_hold", int'(result), exp_prev);
        sb.push_back('{r, cyc + 8});
        exp_prev = r;
        repeat (hold - 1) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!Done && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("done_timeout", int'(Done), 1);
        @(negedge clk);
    endtask

    initial begin
        int ok;
        rst_n = 1'b0;
        start = 1'b0;
        data  = '0;
        N     = '0;
        key   = '0;
        #1;
        check("reset_result", int'(result), 0);
        check("reset_done", int'(Done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Start held three cycles launches once; then check stability.
        launch(43, 20, 10, 3);
        wait_done();
        ok = 1;
        repeat (20) begin
            @(negedge clk);
            if (!(Done && result == 6'd9)) ok = 0;
        end
        check("stable", ok, 1);

        // Round trip and relaunch from DONE.
        launch(2, 33, 7, 1);
        wait_done();
        launch(29, 33, 3, 1);
        wait_done();

        // Corner exponents and moduli.
        launch(5, 7, 0, 1);  wait_done();
        launch(5, 1, 3, 1);  wait_done();
        launch(9, 0, 5, 2);  wait_done();
        launch(0, 13, 4, 1); wait_done();
        launch(63, 63, 63, 1); wait_done();
        launch(62, 63, 63, 1); wait_done();

        // Interference at the 4th CALC cycle.
        launch(43, 20, 10, 1);
        repeat (4) @(negedge clk);
        data  = 6'd1;
        N     = 6'd2;
        key   = 6'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Asynchronous reset mid-CALC.
        launch(43, 20, 10, 1);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_result", int'(result), 0);
        check("async_rst_done", int'(Done), 0);
        sb.delete();
        exp_prev = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_done", int'(Done), 0);
        check("idle_result", int'(result), 0);
        launch(3, 11, 5, 1);
        wait_done();

        // Randomized operands.
        for (int i = 0; i < 30; i++) begin
            int d, n, k;
            d = $urandom_range(0, 63);
            n = (i % 4 == 0) ? $urandom_range(0, 3) : $urandom_range(0, 63);
            k = $urandom_range(0, 63);
            launch(d, n, k, $urandom_range(1, 3));
            wait_done();
        end

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
